ecc_lockstep_chk: RTL and testbench

Registered, parametrised successor to the combinational dual-decode ECC fault detector. It runs two redundant SECDED decode cores on each accepted word and compares their results cycle by cycle. It delivers corrected data with a valid strobe, and keeps sticky fault state, saturating error counters and a self-test fault-injection path. It sits on the read side of the FIFO/RAM datapath, between macro read data and the consumer.

---
 rtl/ecc_lockstep_chk.sv | 197 +++++++++++++++++++
 tb/tb_ecc_lockstep_chk.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_lockstep_chk.sv
// rtl/ecc_lockstep_chk.sv - lockstep dual SECDED decode with registered output, sticky fault and counters
// Check bit i sits at codeword position 2^i, data bit j at the j-th non-power-of-two position >= 3.
module ecc_lockstep_chk #(
  parameter int DATA_WIDTH   = 58,
  parameter int PARITY_WIDTH = 8,
  parameter int CNT_WIDTH    = 16,
  parameter int INJ_BIT      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [PARITY_WIDTH-1:0] in_parity,
  input  logic                    bypass,
  input  logic                    detc_en,
  input  logic                    inj_en,
  input  logic                    cnt_clr,
  input  logic                    fault_clr,
  input  logic                    irq_en,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_sbit_err,
  output logic                    out_dbit_err,
  output logic                    out_fault,
  output logic                    fault_sticky,
  output logic                    fault_irq,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [CNT_WIDTH-1:0]    fault_cnt
);

  localparam int SW   = PARITY_WIDTH - 1;
  localparam int NPOS = 1 << SW;

  // Returns {sbit, dbit, mask}; mask is nonzero only for a correctable data-bit error.
  function automatic logic [DATA_WIDTH+1:0] secded_dec(
    input logic [DATA_WIDTH-1:0]   d,
    input logic [PARITY_WIDTH-1:0] p,
    input logic                    byp
  );
    logic [SW-1:0]         syn;
    logic [DATA_WIDTH-1:0] mask;
    logic                  ovr;
    logic                  sbit;
    logic                  dbit;
    int                    j;
    syn  = p[SW-1:0];
    ovr  = ^{d, p};
    mask = '0;
    sbit = 1'b0;
    dbit = 1'b0;
    j    = 0;
    for (int k = 3; k < NPOS; k++) begin
      if ((k & (k - 1)) != 0 && j < DATA_WIDTH) begin
        if (d[j]) syn = syn ^ SW'(k);
        j++;
      end
    end
    j = 0;
    for (int k = 3; k < NPOS; k++) begin
      if ((k & (k - 1)) != 0 && j < DATA_WIDTH) begin
        mask[j] = (syn == SW'(k));
        j++;
      end
    end
    if (ovr) begin
      // Odd overall parity with a syndrome pointing outside the codeword is uncorrectable.
      if (syn != '0 && (syn & (syn - 1'b1)) != '0 && mask == '0) dbit = 1'b1;
      else sbit = 1'b1;
    end else if (syn != '0) begin
      dbit = 1'b1;
    end
    if (!sbit) mask = '0;
    if (byp) begin
      mask = '0;
      sbit = 1'b0;
      dbit = 1'b0;
    end
    return {sbit, dbit, mask};
  endfunction

  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
  logic [PARITY_WIDTH-1:0] s1_parity_q, s1_parity_d;
  logic                    s1_bypass_q, s1_bypass_d;
  logic                    s1_detc_q, s1_detc_d;
  logic                    s1_inj_q, s1_inj_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_sbit_q, out_sbit_d;
  logic                    out_dbit_q, out_dbit_d;
  logic                    out_fault_q, out_fault_d;
  logic                    sticky_q, sticky_d;
  logic                    irq_q, irq_d;
  logic [CNT_WIDTH-1:0]    sbit_cnt_q, sbit_cnt_d;
  logic [CNT_WIDTH-1:0]    dbit_cnt_q, dbit_cnt_d;
  logic [CNT_WIDTH-1:0]    fault_cnt_q, fault_cnt_d;

  logic [DATA_WIDTH+1:0]   dec0, dec1;
  logic [DATA_WIDTH-1:0]   inj_mask;
  logic                    mismatch;

  always_comb begin
    inj_mask          = '0;
    inj_mask[INJ_BIT] = s1_inj_q;
    dec0     = secded_dec(s1_data_q, s1_parity_q, s1_bypass_q);
    dec1     = secded_dec(s1_data_q, s1_parity_q, s1_bypass_q) ^ {2'b00, inj_mask};
    mismatch = (dec0 != dec1);
  end

  always_comb begin
    s1_valid_d  = in_valid;
    s1_data_d   = in_valid ? in_data   : s1_data_q;
    s1_parity_d = in_valid ? in_parity : s1_parity_q;
    s1_bypass_d = in_valid ? bypass    : s1_bypass_q;
    s1_detc_d   = in_valid ? detc_en   : s1_detc_q;
    s1_inj_d    = in_valid ? inj_en    : s1_inj_q;

    out_valid_d = s1_valid_q;
    out_data_d  = out_data_q;
    out_sbit_d  = out_sbit_q;
    out_dbit_d  = out_dbit_q;
    out_fault_d = out_fault_q;
    if (s1_valid_q) begin
      out_fault_d = mismatch & s1_detc_q;
      out_data_d  = out_fault_d ? s1_data_q : (s1_data_q ^ dec0[DATA_WIDTH-1:0]);
      out_sbit_d  = dec0[DATA_WIDTH+1];
      out_dbit_d  = dec0[DATA_WIDTH];
    end

    sbit_cnt_d  = sbit_cnt_q;
    dbit_cnt_d  = dbit_cnt_q;
    fault_cnt_d = fault_cnt_q;
    if (out_valid_q && out_sbit_q && sbit_cnt_q != '1)   sbit_cnt_d  = sbit_cnt_q + 1'b1;
    if (out_valid_q && out_dbit_q && dbit_cnt_q != '1)   dbit_cnt_d  = dbit_cnt_q + 1'b1;
    if (out_valid_q && out_fault_q && fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + 1'b1;
    if (cnt_clr) begin
      sbit_cnt_d  = '0;
      dbit_cnt_d  = '0;
      fault_cnt_d = '0;
    end

    // A new fault outranks a same-cycle clear.
    sticky_d = (out_valid_q & out_fault_q) | (sticky_q & ~fault_clr);
    irq_d    = sticky_q & irq_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_parity_q <= '0;
      s1_bypass_q <= 1'b0;
      s1_detc_q   <= 1'b0;
      s1_inj_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sbit_q  <= 1'b0;
      out_dbit_q  <= 1'b0;
      out_fault_q <= 1'b0;
      sticky_q    <= 1'b0;
      irq_q       <= 1'b0;
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      fault_cnt_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_parity_q <= s1_parity_d;
      s1_bypass_q <= s1_bypass_d;
      s1_detc_q   <= s1_detc_d;
      s1_inj_q    <= s1_inj_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sbit_q  <= out_sbit_d;
      out_dbit_q  <= out_dbit_d;
      out_fault_q <= out_fault_d;
      sticky_q    <= sticky_d;
      irq_q       <= irq_d;
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sbit_err = out_sbit_q;
  assign out_dbit_err = out_dbit_q;
  assign out_fault    = out_fault_q;
  assign fault_sticky = sticky_q;
  assign fault_irq    = irq_q;
  assign sbit_cnt     = sbit_cnt_q;
  assign dbit_cnt     = dbit_cnt_q;
  assign fault_cnt    = fault_cnt_q;

endmodule

// File: tb/tb_ecc_lockstep_chk.sv
// tb/tb_ecc_lockstep_chk.sv - scoreboard bench for ecc_lockstep_chk
// Expected responses come from the known error pattern of each word, not from decoding it.
module tb_ecc_lockstep_chk;
  localparam int DW = 58;
  localparam int PW = 8;
  localparam int CW = 4;
  localparam int NB = DW + PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [PW-1:0] in_parity = '0;
  logic          bypass = 1'b0, detc_en = 1'b1, inj_en = 1'b0;
  logic          cnt_clr = 1'b0, fault_clr = 1'b0, irq_en = 1'b0;
  logic          out_valid, out_sbit_err, out_dbit_err, out_fault, fault_sticky, fault_irq;
  logic [DW-1:0] out_data;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;

  ecc_lockstep_chk #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW), .INJ_BIT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_parity(in_parity),
    .bypass(bypass), .detc_en(detc_en), .inj_en(inj_en), .cnt_clr(cnt_clr),
    .fault_clr(fault_clr), .irq_en(irq_en), .out_valid(out_valid), .out_data(out_data),
    .out_sbit_err(out_sbit_err), .out_dbit_err(out_dbit_err), .out_fault(out_fault),
    .fault_sticky(fault_sticky), .fault_irq(fault_irq), .sbit_cnt(sbit_cnt),
    .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [DW-1:0] data;
    logic          sbit;
    logic          dbit;
    logic          fault;
    int            cyc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Check bit i covers every data position with bit i set; top bit is overall parity.
  function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
    logic [PW-2:0] c;
    int pos;
    c = '0;
    pos = 3;
    for (int j = 0; j < DW; j++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      if (d[j]) c = c ^ (PW-1)'(pos);
      pos++;
    end
    return {^{d, c}, c};
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic send(input logic [DW-1:0] d, input int b0, input int b1,
                      input bit byp, input bit detc, input bit inj);
    logic [NB-1:0] cw;
    exp_t e;
    int n;
    cw = {enc(d), d};
    n = 0;
    if (b0 >= 0) begin cw[b0] = ~cw[b0]; n++; end
    if (b1 >= 0) begin cw[b1] = ~cw[b1]; n++; end
    e.sbit  = !byp && n == 1;
    e.dbit  = !byp && n == 2;
    e.fault = inj && detc;
    e.data  = (e.fault || byp || n == 2) ? cw[DW-1:0] : d;
    e.cyc   = cyc;
    q.push_back(e);
    in_valid  = 1'b1;
    in_data   = cw[DW-1:0];
    in_parity = cw[NB-1:DW];
    bypass    = byp;
    detc_en   = detc;
    inj_en    = inj;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid  = 1'b0;
      in_data   = rnd_word();
      in_parity = PW'($urandom());
      bypass    = 1'($urandom());
      detc_en   = 1'($urandom());
      inj_en    = 1'($urandom());
      @(posedge clk); #1;
    end
  endtask

  task automatic send_rand(input bit byp, input bit detc, input bit inj);
    int t, b0, b1;
    t  = $urandom_range(0, 3);
    b0 = -1;
    b1 = -1;
    if (t == 1) b0 = $urandom_range(0, DW - 1);
    if (t == 2) b0 = $urandom_range(DW, NB - 1);
    if (t == 3) begin
      b0 = $urandom_range(0, NB - 1);
      b1 = (b0 + $urandom_range(1, NB - 1)) % NB;
    end
    send(rnd_word(), b0, b1, byp, detc, inj);
  endtask

  // Reference state for counters, sticky fault and irq, advanced once per cycle.
  bit m_rstd = 1'b1;
  bit m_sticky = 1'b0, m_irq = 1'b0;
  int m_sc = 0, m_dc = 0, m_fc = 0;

  always @(negedge clk) begin
    exp_t e;
    bit vs, vd, vf;
    vs = 1'b0; vd = 1'b0; vf = 1'b0;
    if (m_rstd) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_flags", 64'({out_sbit_err, out_dbit_err, out_fault}), 64'd0);
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_sbit_err", 64'(out_sbit_err), 64'(e.sbit));
        chk("out_dbit_err", 64'(out_dbit_err), 64'(e.dbit));
        chk("out_fault", 64'(out_fault), 64'(e.fault));
        chk("latency", 64'(cyc - e.cyc), 64'd2);
        vs = e.sbit; vd = e.dbit; vf = e.fault;
      end
    end else if (q.size() > 0 && cyc - q[0].cyc > 2) begin
      e = q.pop_front();
      chk("missing_out_valid", 64'(out_valid), 64'd1);
    end
    chk("sbit_cnt", 64'(sbit_cnt), 64'(m_sc));
    chk("dbit_cnt", 64'(dbit_cnt), 64'(m_dc));
    chk("fault_cnt", 64'(fault_cnt), 64'(m_fc));
    chk("fault_sticky", 64'(fault_sticky), 64'(m_sticky));
    chk("fault_irq", 64'(fault_irq), 64'(m_irq));

    if (rst) begin
      m_rstd = 1'b1; m_sticky = 1'b0; m_irq = 1'b0;
      m_sc = 0; m_dc = 0; m_fc = 0;
    end else begin
      m_rstd = 1'b0;
      m_irq = m_sticky && irq_en;
      m_sticky = vf || (m_sticky && !fault_clr);
      if (cnt_clr) begin
        m_sc = 0; m_dc = 0; m_fc = 0;
      end else begin
        if (vs) m_sc = (m_sc < (1 << CW) - 1) ? m_sc + 1 : m_sc;
        if (vd) m_dc = (m_dc < (1 << CW) - 1) ? m_dc + 1 : m_dc;
        if (vf) m_fc = (m_fc < (1 << CW) - 1) ? m_fc + 1 : m_fc;
      end
    end
  end

  initial begin
    // Valid words during reset must be dropped.
    in_valid = 1'b1; in_data = rnd_word(); in_parity = PW'($urandom());
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Clean stream with random gaps.
    for (int i = 0; i < 100; i++) begin
      send(rnd_word(), -1, -1, 1'b0, 1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    // Single-bit errors: data bit 0, data bit 57, one parity bit.
    send(rnd_word(), 0, -1, 1'b0, 1'b1, 1'b0);
    send(rnd_word(), DW - 1, -1, 1'b0, 1'b1, 1'b0);
    send(rnd_word(), $urandom_range(DW, NB - 1), -1, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Double-bit error.
    send(rnd_word(), 3, 9, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Injection with and without lockstep compare.
    irq_en = 1'b1;
    send(rnd_word(), -1, -1, 1'b0, 1'b1, 1'b1);
    idle(4);
    send(rnd_word(), 5, -1, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Clear, then a fault arriving on the same edge as fault_clr.
    fault_clr = 1'b1; idle(1); fault_clr = 1'b0; idle(2);
    send(rnd_word(), -1, -1, 1'b0, 1'b1, 1'b1);
    idle(1);
    fault_clr = 1'b1; idle(1); fault_clr = 1'b0;
    idle(3);
    fault_clr = 1'b1; idle(1); fault_clr = 1'b0; idle(2);

    // Saturation of the 4-bit sbit counter.
    for (int i = 0; i < 20; i++) send(rnd_word(), $urandom_range(0, NB - 1), -1, 1'b0, 1'b1, 1'b0);
    idle(3);

    // cnt_clr on the same edge as an increment.
    send(rnd_word(), 7, -1, 1'b0, 1'b1, 1'b0);
    idle(1);
    cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
    idle(2);

    // Bypass passes raw data without flags.
    for (int i = 0; i < 6; i++) send_rand(1'b1, 1'b1, 1'b0);
    idle(3);

    // Reset with two words in flight.
    send(rnd_word(), -1, -1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1; in_data = rnd_word(); in_parity = enc(in_data);
    q.delete();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Randomized mix of everything.
    for (int i = 0; i < 150; i++) begin
      cnt_clr   = ($urandom_range(0, 15) == 0);
      fault_clr = ($urandom_range(0, 7) == 0);
      irq_en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) idle(1);
      else send_rand(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
    end
    cnt_clr = 1'b0; fault_clr = 1'b0;
    idle(5);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
